dram_dmac: RTL

- Word-granular DMA engine that copies blocks between on-chip data SRAM and DDR.
- Sits directly upstream of jtag_adapter and drives its simple request interface (dramAddress / dramWriteData / readEnable / writeEnable, answered by dramReadData / dramValid).
- Started by the MIPS core through memory-mapped registers, which live outside this block. Two directions: D2S (DRAM to SRAM) and S2D (SRAM to DRAM).

---
 rtl/dram_dmac_pkg.sv | 25 ++
 rtl/dram_dmac.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_dmac_pkg.sv
// ---------------------------------------------------------------------------
// dram_dmac_pkg
// Shared definitions for the dram_dmac word-granular DMA engine:
//   - dmac_state_t    : engine FSM state encoding
//   - DIR_D2S/DIR_S2D : transfer direction codes (value of the dir input)
//   - DRAM_WORD_BYTES : byte stride of one DRAM word
// ---------------------------------------------------------------------------
package dram_dmac_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_D2S_REQ  = 3'd1,
        S_D2S_WR   = 3'd2,
        S_S2D_RD   = 3'd3,
        S_S2D_WAIT = 3'd4,
        S_S2D_REQ  = 3'd5,
        S_GAP      = 3'd6,
        S_DONE     = 3'd7
    } dmac_state_t;

    localparam logic        DIR_D2S         = 1'b0;
    localparam logic        DIR_S2D         = 1'b1;
    localparam logic [31:0] DRAM_WORD_BYTES = 32'd4;

endpackage

// File: rtl/dram_dmac.sv
// ---------------------------------------------------------------------------
// dram_dmac
// Copies blocks of 32-bit words between on-chip data SRAM and DDR through the
// jtag_adapter request interface. One word is in flight at a time; every
// DRAM request is followed by a one-cycle GAP with both enables low so the
// adapter can return to dormant before the next request.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, dir           start pulse; direction (0 = D2S, 1 = S2D)
//   srcDramAddr          DRAM byte address (word aligned), sampled on start
//   sramBase, len        SRAM word address and word count, sampled on start
//   busy, done, error    status: in progress, completion pulse, sticky timeout
//   sramAddress/sramWriteEnable/sramWriteData/sramReadData
//                        SRAM port (read data one cycle after address)
//   dramAddress/dramWriteData/dramReadEnable/dramWriteEnable
//                        request to jtag_adapter
//   dramReadData/dramValid
//                        response from jtag_adapter
//
// Build option: DRAM_DMAC_TIMEOUT_EN adds a per-request watchdog of
// TIMEOUT_CYCLES cycles; without it error is tied low and requests wait
// indefinitely.
// ---------------------------------------------------------------------------
module dram_dmac
    import dram_dmac_pkg::*;
#(
    parameter int SRAM_AW        = 14,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               dir,
    input  logic [31:0]        srcDramAddr,
    input  logic [SRAM_AW-1:0] sramBase,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [SRAM_AW-1:0] sramAddress,
    output logic               sramWriteEnable,
    output logic [31:0]        sramWriteData,
    input  logic [31:0]        sramReadData,
    output logic [31:0]        dramAddress,
    output logic [31:0]        dramWriteData,
    output logic               dramReadEnable,
    output logic               dramWriteEnable,
    input  logic [31:0]        dramReadData,
    input  logic               dramValid
);

    dmac_state_t        r_state;
    logic               r_dir;
    logic [31:0]        r_dram_addr;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_busy;
    logic               r_done;
    logic               r_sram_we;
    logic [31:0]        r_sram_wdata;
    logic [31:0]        r_dram_wdata;
    logic               r_dram_re;
    logic               r_dram_we;

`ifdef DRAM_DMAC_TIMEOUT_EN
    // Counter only has to reach TIMEOUT_CYCLES-1: the expiring cycle is the
    // TIMEOUT_CYCLES-th cycle spent in the request state.
    localparam int          TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_error;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // Engine FSM and datapath registers; done and the SRAM strobe are
    // single-cycle pulses that default low every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_dir        <= DIR_D2S;
            r_dram_addr  <= 32'd0;
            r_sram_addr  <= {SRAM_AW{1'b0}};
            r_remaining  <= {LEN_W{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_wdata <= 32'd0;
            r_dram_wdata <= 32'd0;
            r_dram_re    <= 1'b0;
            r_dram_we    <= 1'b0;
`ifdef DRAM_DMAC_TIMEOUT_EN
            r_tmo_cnt    <= {TMO_W{1'b0}};
            r_error      <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_sram_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef DRAM_DMAC_TIMEOUT_EN
                        r_error   <= 1'b0;
                        r_tmo_cnt <= {TMO_W{1'b0}};
`endif
                        if (len == {LEN_W{1'b0}}) begin
                            r_done <= 1'b1;
                        end else begin
                            r_dir       <= dir;
                            r_dram_addr <= srcDramAddr;
                            r_sram_addr <= sramBase;
                            r_remaining <= len;
                            r_busy      <= 1'b1;
                            if (dir == DIR_S2D) begin
                                r_state <= S_S2D_RD;
                            end else begin
                                r_state   <= S_D2S_REQ;
                                r_dram_re <= 1'b1;
                            end
                        end
                    end
                end
                S_D2S_REQ: begin
                    if (dramValid) begin
                        r_sram_wdata <= dramReadData;
                        r_dram_re    <= 1'b0;
                        r_sram_we    <= 1'b1;
                        r_state      <= S_D2S_WR;
                    end
`ifdef DRAM_DMAC_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_dram_re <= 1'b0;
                        r_error   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                S_D2S_WR: begin
                    r_state <= S_GAP;
                end
                S_S2D_RD: begin
                    r_state <= S_S2D_WAIT;
                end
                S_S2D_WAIT: begin
                    r_dram_wdata <= sramReadData;
                    r_dram_we    <= 1'b1;
                    r_state      <= S_S2D_REQ;
`ifdef DRAM_DMAC_TIMEOUT_EN
                    r_tmo_cnt    <= {TMO_W{1'b0}};
`endif
                end
                S_S2D_REQ: begin
                    if (dramValid) begin
                        r_dram_we <= 1'b0;
                        r_state   <= S_GAP;
                    end
`ifdef DRAM_DMAC_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_dram_we <= 1'b0;
                        r_error   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                S_GAP: begin
                    // Both enables are already low here; dramValid is ignored.
                    r_remaining <= r_remaining - LEN_W'(1);
                    r_dram_addr <= r_dram_addr + DRAM_WORD_BYTES;
                    r_sram_addr <= r_sram_addr + SRAM_AW'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_dir == DIR_S2D) begin
                        r_state <= S_S2D_RD;
                    end else begin
                        r_state   <= S_D2S_REQ;
                        r_dram_re <= 1'b1;
`ifdef DRAM_DMAC_TIMEOUT_EN
                        r_tmo_cnt <= {TMO_W{1'b0}};
`endif
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_dram_re <= 1'b0;
                    r_dram_we <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign sramAddress     = r_sram_addr;
    assign sramWriteEnable = r_sram_we;
    assign sramWriteData   = r_sram_wdata;
    assign dramAddress     = r_dram_addr;
    assign dramWriteData   = r_dram_wdata;
    assign dramReadEnable  = r_dram_re;
    assign dramWriteEnable = r_dram_we;
`ifdef DRAM_DMAC_TIMEOUT_EN
    assign error           = r_error;
`else
    assign error           = 1'b0;
`endif

endmodule
